// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command assembler.
// Optional feature: define CMD_CHKSUM_EN for 3-byte frames with a checksum byte.
package uart_cmd_pkg;

  // Default inter-byte timeout: 10 byte times at 19200 baud with a 50 MHz clock.
  localparam int DEF_TIMEOUT_CYC = 260400;
  localparam int DEF_TO_W        = 19;

  // Frame assembly states.
  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_CK = 2'd2
  } state_e;

  // Checksum byte for a frame: bitwise inverse of the 8-bit sum of high and low bytes.
  function automatic logic [7:0] chksum(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] sum;
    sum = hi + lo;
    return ~sum;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter. Cleared while idle or when a byte is taken,
// counts while a frame waits for its next byte, saturates at the last cycle.
module frame_timer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = DEF_TO_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] ONE_CNT  = TO_W'(1);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  // Next count: clear has priority, then increment until the last cycle, then hold.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {TO_W{1'b0}};
    end else if (enable_i && (count_q != LAST_CNT)) begin
      count_d = count_q + ONE_CNT;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {TO_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry only counts while the frame is actually waiting.
  assign expire_o = enable_i & (count_q == LAST_CNT);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles UART bytes (high byte first) into 16-bit commands with an
// inter-byte timeout that drops half-received frames.
// Optional feature: define CMD_CHKSUM_EN for a trailing checksum byte.
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = DEF_TO_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frame_err
);

  state_e      state_q;
  logic [7:0]  hi_byte_q;
`ifdef CMD_CHKSUM_EN
  logic [7:0]  lo_byte_q;
`endif
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;
  logic        frame_err_q;

  logic        timer_clear_s;
  logic        timer_en_s;
  logic        timer_expire_s;

  // Every byte presented is taken in the same cycle, in any state.
  assign clr_rx_rdy = rx_rdy & rst_n;

  // Timer restarts whenever a byte is taken and idles in WAIT_HI.
  assign timer_clear_s = (state_q == WAIT_HI) | rx_rdy;
  assign timer_en_s    = (state_q != WAIT_HI) & ~rx_rdy;

  frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_frame_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (timer_clear_s),
    .enable_i (timer_en_s),
    .expire_o (timer_expire_s)
  );

  // Frame FSM with registered command, ready flag and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_HI;
      hi_byte_q   <= 8'h00;
`ifdef CMD_CHKSUM_EN
      lo_byte_q   <= 8'h00;
`endif
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      // Consumer acknowledge; a completing frame below overrides it.
      if (clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
      case (state_q)
        WAIT_HI: begin
          if (rx_rdy) begin
            hi_byte_q <= rx_data;
            cmd_rdy_q <= 1'b0;
            state_q   <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (rx_rdy) begin
`ifdef CMD_CHKSUM_EN
            lo_byte_q <= rx_data;
            state_q   <= WAIT_CK;
`else
            cmd_q     <= {hi_byte_q, rx_data};
            cmd_rdy_q <= 1'b1;
            state_q   <= WAIT_HI;
`endif
          end else if (timer_expire_s) begin
            frame_err_q <= 1'b1;
            hi_byte_q   <= 8'h00;
            state_q     <= WAIT_HI;
          end
        end
`ifdef CMD_CHKSUM_EN
        WAIT_CK: begin
          if (rx_rdy) begin
            if (rx_data == chksum(hi_byte_q, lo_byte_q)) begin
              cmd_q     <= {hi_byte_q, lo_byte_q};
              cmd_rdy_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= WAIT_HI;
          end else if (timer_expire_s) begin
            frame_err_q <= 1'b1;
            hi_byte_q   <= 8'h00;
            lo_byte_q   <= 8'h00;
            state_q     <= WAIT_HI;
          end
        end
`endif
        default: begin
          state_q <= WAIT_HI;
        end
      endcase
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed plus randomized bench for uart_cmd_assembler against a frame-level
// reference model (byte list + gaps -> expected commands, errors, acks).
module tb_uart_cmd_assembler;

  localparam int T  = 300;
  localparam int TW = 9;
`ifdef CMD_CHKSUM_EN
  localparam int FRAME_LEN = 3;
`else
  localparam int FRAME_LEN = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frame_err;

  uart_cmd_assembler #(.TIMEOUT_CYC(T), .TO_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int clr_seen = 0;
  int err_seen = 0;

  // Count acknowledge pulses at the edge where bytes are taken.
  always @(posedge clk) if (clr_rx_rdy) clr_seen <= clr_seen + 1;
  // Count error pulses away from the edge that produces them.
  always @(negedge clk) if (frame_err) err_seen <= err_seen + 1;

  // Reference model: frame progress and expected visible state.
  int          stage = 0;      // bytes of the current frame already taken
  int          m_hi = 0;
  int          m_lo = 0;
  logic [15:0] m_cmd = 16'h0000;
  logic        m_rdy = 1'b0;
  int          m_err = 0;
  int          m_bytes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cmd"}, {16'h0000, cmd}, {16'h0000, m_cmd});
    chk({tag, "_rdy"}, {31'd0, cmd_rdy}, {31'd0, m_rdy});
    chk({tag, "_errs"}, err_seen, m_err);
    chk({tag, "_acks"}, clr_seen, m_bytes);
  endtask

  // Present one byte gap cycles after the previous acceptance edge.
  task automatic send(input logic [7:0] b, input int gap, input logic clr);
    // Model: a waiting frame older than the timeout was dropped before this byte.
    if (stage != 0 && gap >= T) begin
      m_err++;
      stage = 0;
    end
    m_bytes++;
    if (clr) m_rdy = 1'b0;
    if (stage == 0) begin
      m_hi  = int'(b);
      m_rdy = 1'b0;
      stage = 1;
    end else if (stage == 1 && FRAME_LEN == 3) begin
      m_lo  = int'(b);
      stage = 2;
    end else if (stage == 1) begin
      m_cmd = 16'(m_hi * 256 + int'(b));
      m_rdy = 1'b1;
      stage = 0;
    end else begin
      if ((m_hi + m_lo + int'(b)) % 256 == 255) begin
        m_cmd = 16'(m_hi * 256 + m_lo);
        m_rdy = 1'b1;
      end else begin
        m_err++;
      end
      stage = 0;
    end
    // Drive.
    repeat (gap + 1) @(negedge clk);
    chk("ack_idle", {31'd0, clr_rx_rdy}, 32'd0);
    rx_rdy = 1'b1;
    rx_data = b;
    clr_cmd_rdy = clr;
    #1;
    chk("ack_same_cycle", {31'd0, clr_rx_rdy}, 32'd1);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    rx_data = 8'($urandom);
    #1;
    chk_state("byte");
  endtask

  // Complete frame (checksum byte appended when enabled); clr rides on the last byte.
  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo,
                            input int gap_hi, input int gap_lo, input logic clr);
`ifdef CMD_CHKSUM_EN
    logic [7:0] ck;
    ck = 8'(255 - ((int'(hi) + int'(lo)) % 256));
    send(hi, gap_hi, 1'b0);
    send(lo, gap_lo, 1'b0);
    send(ck, 0, clr);
`else
    send(hi, gap_hi, 1'b0);
    send(lo, gap_lo, clr);
`endif
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    #1;
    chk_state("clr_pulse");
  endtask

  // Idle past the timeout so any half frame is dropped.
  task automatic flush();
    repeat (T + 3) @(negedge clk);
    if (stage != 0) begin
      m_err++;
      stage = 0;
    end
    #1;
    chk_state("flush");
  endtask

  int         acks0;
  int         errs0;
  logic [7:0] rb;
  int         rgap;
  logic       rclr;

  initial begin
    // Reset values.
    #12;
    chk("rst_cmd", {16'h0000, cmd}, 32'h0000);
    chk("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_ack", {31'd0, clr_rx_rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic frame with a 200-cycle inter-byte gap.
    acks0 = clr_seen;
    send_frame(8'hA5, 8'h3C, 2, 199, 1'b0);
    chk("t1_cmd", {16'h0000, cmd}, 32'h0000A53C);
    chk("t1_ack_count", clr_seen - acks0, FRAME_LEN);

    // 2: half frame times out, next frame resyncs.
    errs0 = err_seen;
    send(8'h12, 5, 1'b0);
    send_frame(8'h34, 8'h56, T, 3, 1'b0);
    chk("t2_err_count", err_seen - errs0, 1);
    chk("t2_cmd", {16'h0000, cmd}, 32'h00003456);

    // 3: acknowledge on the completing edge loses; a later acknowledge clears.
    send_frame(8'h77, 8'h88, 1, 2, 1'b1);
    chk("t3_set_wins", {31'd0, cmd_rdy}, 32'd1);
    pulse_clr();
    chk("t3_cleared", {31'd0, cmd_rdy}, 32'd0);

    // 4: reset after a high byte discards it.
    send(8'hFF, 1, 1'b0);
    rst_n = 1'b0;
    #3;
    stage = 0;
    m_cmd = 16'h0000;
    m_rdy = 1'b0;
    chk("t4_rst_cmd", {16'h0000, cmd}, 32'h0000);
    chk("t4_rst_rdy", {31'd0, cmd_rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    errs0 = err_seen;
    send_frame(8'h01, 8'h02, 4, 1, 1'b0);
    chk("t4_cmd", {16'h0000, cmd}, 32'h00000102);
    flush();
    chk("t4_no_err", err_seen - errs0, 0);

`ifdef CMD_CHKSUM_EN
    // 5: good and bad checksum.
    send(8'h10, 2, 1'b0);
    send(8'h20, 2, 1'b0);
    send(8'hCF, 2, 1'b0);
    chk("t5_good", {16'h0000, cmd}, 32'h00001020);
    errs0 = err_seen;
    send(8'h10, 2, 1'b0);
    send(8'h20, 2, 1'b0);
    send(8'h00, 2, 1'b0);
    chk("t5_bad_err", err_seen - errs0, 1);
    chk("t5_bad_cmd", {16'h0000, cmd}, 32'h00001020);
`endif

    // 6: next byte exactly on the timeout cycle still completes the frame.
    errs0 = err_seen;
    send_frame(8'h9A, 8'hBC, 1, T - 1, 1'b0);
    chk("t6_cmd", {16'h0000, cmd}, 32'h00009ABC);
    chk("t6_no_err", err_seen - errs0, 0);

    // Randomized byte stream with gaps clustered around the timeout boundary.
    for (int i = 0; i < 150; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rgap = int'($urandom_range(T - 2, T + 1));
      else rgap = int'($urandom_range(0, 12));
      rclr = ($urandom_range(0, 3) == 0);
      if (stage == 2 && $urandom_range(0, 1) == 1)
        rb = 8'(255 - ((m_hi + m_lo) % 256));
      send(rb, rgap, rclr);
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
